// File: rtl/cplx_pp_seq.sv
// cplx_pp_seq: ar*br, ai*bi, ar*bi, ai*br on one shared multiplier over 4 cycles; CPLX_PP_ZERO_SKIP_EN skips steps with a zero operand
module cplx_pp_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   ar,
  input  logic [W-1:0]   ai,
  input  logic [W-1:0]   br,
  input  logic [W-1:0]   bi,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p_rr,
  output logic [2*W-1:0] p_ii,
  output logic [2*W-1:0] p_ri,
  output logic [2*W-1:0] p_ir
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [W-1:0] ar_q, ai_q, br_q, bi_q, ar_d, ai_d, br_d, bi_d;
  logic [2*W-1:0] p_q [4];
  logic [2*W-1:0] p_d [4];
  logic [W-1:0] mul_a, mul_b;
  logic [2*W-1:0] prod;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign p_rr = p_q[0];
  assign p_ii = p_q[1];
  assign p_ri = p_q[2];
  assign p_ir = p_q[3];
  assign mul_a = step_q[0] ? ai_q : ar_q;
  assign mul_b = (step_q[0] ^ step_q[1]) ? bi_q : br_q;
  assign prod  = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
`ifdef CPLX_PP_ZERO_SKIP_EN
  logic [3:0] mask_q, mask_d, m_in, rem;
  assign m_in = {ai != '0 && br != '0, ar != '0 && bi != '0, ai != '0 && bi != '0, ar != '0 && br != '0};
  assign rem  = mask_q & (4'b1110 << step_q);
  function automatic logic [1:0] low(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
`endif
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ar_d    = ar_q;
    ai_d    = ai_q;
    br_d    = br_q;
    bi_d    = bi_q;
    p_d     = p_q;
`ifdef CPLX_PP_ZERO_SKIP_EN
    mask_d  = mask_q;
`endif
    if (state_q == IDLE && in_valid) begin
      {ar_d, ai_d, br_d, bi_d} = {ar, ai, br, bi};
      p_d = '{default: '0};
`ifdef CPLX_PP_ZERO_SKIP_EN
      mask_d  = m_in;
      step_d  = low(m_in);
      state_d = m_in == '0 ? DONE : MUL;
`else
      step_d  = '0;
      state_d = MUL;
`endif
    end else if (state_q == MUL) begin
      p_d[step_q] = prod;
`ifdef CPLX_PP_ZERO_SKIP_EN
      step_d  = low(rem);
      state_d = rem == '0 ? DONE : MUL;
`else
      step_d  = step_q + 2'd1;
      state_d = step_q == 2'd3 ? DONE : MUL;
`endif
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
      p_q     <= '{default: '0};
`ifdef CPLX_PP_ZERO_SKIP_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ar_q    <= ar_d;
      ai_q    <= ai_d;
      br_q    <= br_d;
      bi_q    <= bi_d;
      p_q     <= p_d;
`ifdef CPLX_PP_ZERO_SKIP_EN
      mask_q  <= mask_d;
`endif
    end
  end
endmodule
